bus_rw_control: RTL and testbench

Read/write control stage sitting directly upstream of the internal/external data-bus buffer. Qualifies the host strobes (`cs_n`, `rd_n`, `wr_n`, `addr`) and sequences a read or write transfer. It drives the buffer's two direction controls plus a port-select, output-enable and write-strobe to the port registers on the internal bus. Exactly one transfer is handled at a time.

---
 rtl/bus_rw_pkg.sv | 42 ++++
 rtl/sync2.sv | 25 ++
 rtl/bus_rw_control.sv | 154 +++++++++++++++
 tb/tb_bus_rw_control.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_rw_pkg.sv
// Shared types and constants for the bus read/write control stage.
package bus_rw_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned SEL_W  = 4;

  // Register addresses decoded from the host address lines
  localparam logic [ADDR_W-1:0] ADDR_PA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PB = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_PC = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CW = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_CAP    = 3'd1,
    RD_DRV    = 3'd2,
    WR_CAP    = 3'd3,
    WR_COMMIT = 3'd4,
    ERR       = 3'd5
  } state_e;

  // Buffer direction and port-register control bundle
  typedef struct packed {
    logic int_rd_wr;
    logic rd_wr;
    logic port_oe;
    logic port_we;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE      = '{int_rd_wr: 1'b0, rd_wr: 1'b1, port_oe: 1'b0, port_we: 1'b0};
  localparam ctrl_t CTRL_RD_CAP    = '{int_rd_wr: 1'b0, rd_wr: 1'b1, port_oe: 1'b1, port_we: 1'b0};
  localparam ctrl_t CTRL_RD_DRV    = '{int_rd_wr: 1'b1, rd_wr: 1'b0, port_oe: 1'b0, port_we: 1'b0};
  localparam ctrl_t CTRL_WR_CAP    = '{int_rd_wr: 1'b1, rd_wr: 1'b1, port_oe: 1'b0, port_we: 1'b0};
  localparam ctrl_t CTRL_WR_COMMIT = '{int_rd_wr: 1'b1, rd_wr: 1'b0, port_oe: 1'b0, port_we: 1'b1};
  localparam ctrl_t CTRL_ERR       = '{int_rd_wr: 1'b0, rd_wr: 1'b1, port_oe: 1'b0, port_we: 1'b0};

  // One-hot register select from a binary address
  function automatic logic [SEL_W-1:0] addr_to_sel(input logic [ADDR_W-1:0] a);
    return SEL_W'(1) << a;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Metastability stage followed by the output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_rw_control.sv
// Read/write control stage in front of the data-bus buffer.
// Optional build macro RW_SYNC_EN: adds 2-flop synchronizers on the host
// inputs for asynchronous hosts (two extra cycles of input latency).
module bus_rw_control
  import bus_rw_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [ADDR_W-1:0] addr,
  output logic              int_rd_wr,
  output logic              rd_wr,
  output logic [SEL_W-1:0]  port_sel,
  output logic              port_oe,
  output logic              port_we,
  output logic              busy,
  output logic              err
);

  localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic              cs_s, rd_s, wr_s;
  logic [ADDR_W-1:0] addr_s;

`ifdef RW_SYNC_EN
  sync2 #(.WIDTH(3), .RST_VAL(3'b111)) u_sync_strb (
    .clk (clk),
    .rst (rst),
    .d   ({cs_n, rd_n, wr_n}),
    .q   ({cs_s, rd_s, wr_s})
  );

  sync2 #(.WIDTH(ADDR_W), .RST_VAL('0)) u_sync_addr (
    .clk (clk),
    .rst (rst),
    .d   (addr),
    .q   (addr_s)
  );
`else
  assign cs_s   = cs_n;
  assign rd_s   = rd_n;
  assign wr_s   = wr_n;
  assign addr_s = addr;
`endif

  logic              cs_q, rd_q, wr_q;
  logic              rd_prev, wr_prev;
  logic [ADDR_W-1:0] addr_q;

  // Edge-detect register: current sample plus previous strobe levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
      addr_q  <= '0;
    end else begin
      cs_q    <= cs_s;
      rd_q    <= rd_s;
      wr_q    <= wr_s;
      rd_prev <= rd_q;
      wr_prev <= wr_q;
      addr_q  <= addr_s;
    end
  end

  // A transfer only starts on a fresh high-to-low strobe edge while selected
  logic rd_start, wr_start;
  assign rd_start = ~cs_q & ~rd_q & rd_prev;
  assign wr_start = ~cs_q & ~wr_q & wr_prev;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_d;
  ctrl_t            ctrl_d;

  // Next-state, hold counter, port select and next-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = port_sel;
    ctrl_d  = CTRL_IDLE;

    case (state_q)
      IDLE: begin
        if (rd_start && wr_start) state_d = ERR;
        else if (rd_start)        state_d = RD_CAP;
        else if (wr_start)        state_d = WR_CAP;
      end
      RD_CAP: begin
        state_d = RD_DRV;
        cnt_d   = CNT_LOAD;
      end
      RD_DRV: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cs_q || ((cnt_q == '0) && rd_q)) state_d = IDLE;
      end
      WR_CAP: begin
        if (cs_q)      state_d = IDLE;
        else if (wr_q) state_d = WR_COMMIT;
      end
      WR_COMMIT: state_d = IDLE;
      ERR: begin
        if (rd_q && wr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE)                          sel_d = '0;
    else if (state_q == IDLE)                     sel_d = addr_to_sel(addr_q);

    case (state_d)
      RD_CAP:    ctrl_d = CTRL_RD_CAP;
      RD_DRV:    ctrl_d = CTRL_RD_DRV;
      WR_CAP:    ctrl_d = CTRL_WR_CAP;
      WR_COMMIT: ctrl_d = CTRL_WR_COMMIT;
      ERR:       ctrl_d = CTRL_ERR;
      default:   ctrl_d = CTRL_IDLE;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      port_sel  <= '0;
      int_rd_wr <= CTRL_IDLE.int_rd_wr;
      rd_wr     <= CTRL_IDLE.rd_wr;
      port_oe   <= CTRL_IDLE.port_oe;
      port_we   <= CTRL_IDLE.port_we;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_sel  <= sel_d;
      int_rd_wr <= ctrl_d.int_rd_wr;
      rd_wr     <= ctrl_d.rd_wr;
      port_oe   <= ctrl_d.port_oe;
      port_we   <= ctrl_d.port_we;
      busy      <= (state_d != IDLE);
      err       <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_bus_rw_control.sv
// Directed bench for bus_rw_control with a transfer scoreboard.
module tb_bus_rw_control;

`ifdef RW_SYNC_EN
  localparam int N = 3;
`else
  localparam int N = 1;
`endif
  localparam int HOLD = 2;

  // Expected {int_rd_wr, rd_wr, port_oe, port_we} per phase
  localparam logic [3:0] C_IDLE  = 4'b0100;
  localparam logic [3:0] C_RDCAP = 4'b0110;
  localparam logic [3:0] C_RDDRV = 4'b1000;
  localparam logic [3:0] C_WRCAP = 4'b1100;
  localparam logic [3:0] C_WRCOM = 4'b1001;
  localparam logic [3:0] C_ERR   = 4'b0100;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n, rd_n, wr_n;
  logic [1:0] addr;
  logic       int_rd_wr, rd_wr, port_oe, port_we, busy, err;
  logic [3:0] port_sel;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       is_wr;
    logic [3:0] sel;
  } xfer_t;
  xfer_t sb[$];

  bus_rw_control #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .addr      (addr),
    .int_rd_wr (int_rd_wr),
    .rd_wr     (rd_wr),
    .port_sel  (port_sel),
    .port_oe   (port_oe),
    .port_we   (port_we),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {busy, err, int_rd_wr, rd_wr, port_oe, port_we, port_sel};
  endfunction

  function automatic logic [9:0] mk(input logic b, input logic e, input logic [3:0] c,
                                    input logic [3:0] s);
    return {b, e, c, s};
  endfunction

  function automatic logic [3:0] sel_of(input logic [1:0] a);
    logic [3:0] one;
    one = 4'b0001;
    return one << a;
  endfunction

  localparam logic [9:0] V_IDLE = {1'b0, 1'b0, C_IDLE, 4'b0000};

  // Scoreboard: every port_oe / port_we pulse must match a queued transfer
  always @(negedge clk) begin
    if (rst === 1'b1 && (port_oe === 1'b1 || port_we === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", {30'b0, port_we, port_oe}, 32'd0);
      end else begin
        xfer_t x;
        x = sb.pop_front();
        chk("sb_kind", {31'b0, port_we}, {31'b0, x.is_wr});
        chk("sb_oe_we_exclusive", {31'b0, port_oe & port_we}, 32'd0);
        chk("sb_sel", {28'b0, port_sel}, {28'b0, x.sel});
      end
    end
  end

  // Read with rd_n low for len cycles; exit edge = max(N+HOLD+1, len+N)
  task automatic do_read(input logic [1:0] a, input int len);
    int e;
    e = (N + HOLD + 1 > len + N) ? (N + HOLD + 1) : (len + N);
    @(negedge clk);
    cs_n = 1'b0; addr = a; rd_n = 1'b0;
    sb.push_back('{is_wr: 1'b0, sel: sel_of(a)});
    for (int t = 0; t <= e + 1; t++) begin
      logic [9:0] ev;
      @(negedge clk);
      if (t < N)       ev = V_IDLE;
      else if (t == N) ev = mk(1'b1, 1'b0, C_RDCAP, sel_of(a));
      else if (t < e)  ev = mk(1'b1, 1'b0, C_RDDRV, sel_of(a));
      else             ev = V_IDLE;
      chk($sformatf("read a%0d len%0d t%0d", a, len, t), {22'b0, obs_vec()}, {22'b0, ev});
      if (t == len - 1) rd_n = 1'b1;
    end
    cs_n = 1'b1;
    @(negedge clk);
  endtask

  // Write with wr_n low for len cycles, or aborted by cs_n rising at abort_at
  task automatic do_write(input logic [1:0] a, input int len, input int abort_at);
    int last;
    last = (abort_at > 0) ? (abort_at + N + 1) : (len + N + 2);
    @(negedge clk);
    cs_n = 1'b0; addr = a; wr_n = 1'b0;
    if (abort_at == 0) sb.push_back('{is_wr: 1'b1, sel: sel_of(a)});
    for (int t = 0; t <= last; t++) begin
      logic [9:0] ev;
      @(negedge clk);
      if (t < N)                                ev = V_IDLE;
      else if (abort_at > 0 && t < abort_at + N) ev = mk(1'b1, 1'b0, C_WRCAP, sel_of(a));
      else if (abort_at > 0)                    ev = V_IDLE;
      else if (t < len + N)                     ev = mk(1'b1, 1'b0, C_WRCAP, sel_of(a));
      else if (t == len + N)                    ev = mk(1'b1, 1'b0, C_WRCOM, sel_of(a));
      else                                      ev = V_IDLE;
      chk($sformatf("write a%0d t%0d", a, t), {22'b0, obs_vec()}, {22'b0, ev});
      if (abort_at > 0 && t == abort_at - 1) cs_n = 1'b1;
      if (abort_at == 0 && t == len - 1) wr_n = 1'b1;
    end
    if (abort_at > 0) begin
      // Reselect with wr_n still low: no fresh edge, so no new transfer
      cs_n = 1'b0;
      for (int t = 0; t < N + 3; t++) begin
        @(negedge clk);
        chk($sformatf("no_fresh_edge t%0d", t), {22'b0, obs_vec()}, {22'b0, V_IDLE});
      end
      wr_n = 1'b1;
    end
    cs_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 2'd0;

    // Reset held with strobes toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cs_n = ~cs_n; rd_n = ~rd_n; wr_n = $urandom_range(0, 1) == 0; addr = 2'($urandom_range(0, 3));
      #1;
      chk($sformatf("reset_hold %0d", i), {22'b0, obs_vec()}, {22'b0, V_IDLE});
    end
    @(negedge clk);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 2'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_release", {22'b0, obs_vec()}, {22'b0, V_IDLE});

    do_read(2'd1, 5);
    do_read(2'd0, 1);
    do_write(2'd3, 4, 0);
    do_write(2'd1, 6, 2);
    do_write(2'd2, 1, 0);

    // Both strobes fall together: ERR until both high again
    @(negedge clk);
    cs_n = 1'b0; addr = 2'd2; rd_n = 1'b0; wr_n = 1'b0;
    for (int t = 0; t <= 3 + N + 1; t++) begin
      logic [9:0] ev;
      @(negedge clk);
      if (t < N)          ev = V_IDLE;
      else if (t < 3 + N) ev = mk(1'b1, 1'b1, C_ERR, sel_of(2'd2));
      else                ev = V_IDLE;
      chk($sformatf("err t%0d", t), {22'b0, obs_vec()}, {22'b0, ev});
      if (t == 2) begin rd_n = 1'b1; wr_n = 1'b1; end
    end
    cs_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid RD_DRV takes effect without a clock edge
    @(negedge clk);
    cs_n = 1'b0; addr = 2'd0; rd_n = 1'b0;
    sb.push_back('{is_wr: 1'b0, sel: 4'b0001});
    repeat (N + 3) @(negedge clk);
    chk("pre_reset_in_rd_drv", {22'b0, obs_vec()}, {22'b0, mk(1'b1, 1'b0, C_RDDRV, 4'b0001)});
    #2 rst = 1'b0;
    #1 chk("async_reset", {22'b0, obs_vec()}, {22'b0, V_IDLE});
    @(negedge clk);
    cs_n = 1'b1; rd_n = 1'b1;
    #1 chk("reset_still_held", {22'b0, obs_vec()}, {22'b0, V_IDLE});
    rst = 1'b1;
    repeat (N + 3) @(negedge clk);
    chk("after_reset_idle", {22'b0, obs_vec()}, {22'b0, V_IDLE});

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
